instr_packer: RTL and testbench

INSTR_PACKER -- requirements
Module: instr_packer

---
 rtl/instr_packer.sv | 125 ++++++++++++
 tb/tb_instr_packer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_packer.sv
// instr_packer: encodes instruction field sets into 32-bit words and streams them,
// tagged with sequential program-memory addresses, through a small output FIFO.
module instr_packer #(
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [1:0]    fmt,
    input  logic [5:0]    opcode,
    input  logic [5:0]    func,
    input  logic [4:0]    src_reg1,
    input  logic [4:0]    src_reg2,
    input  logic [4:0]    dest_reg,
    input  logic [4:0]    shamt,
    input  logic [31:0]   imm,
    input  logic [31:0]   imm2,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          done,
    output logic          err,
    output logic [7:0]    err_count
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | accepting field sets
    // DRAIN | final set accepted, emptying the FIFO
    // DONE  | one-cycle end-of-session pulse
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + 32;
    localparam logic [PW:0]   PTR_ONE  = 1;
    localparam logic [AW-1:0] ADDR_ONE = 1;

    state_t          state, state_nxt;
    logic [AW-1:0]   addr;
    logic [31:0]     word;
    logic            illegal;
    logic            accept, push, pop;
    logic            empty, full;
    logic [PW:0]     wr_ptr, rd_ptr;
    logic [EW-1:0]   fifo_mem [DEPTH];
    logic [EW-1:0]   head;

    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        unique case (fmt)
            2'b00: word = {opcode, src_reg1, src_reg2, dest_reg, shamt, func};
            2'b01: begin
                word    = {opcode, src_reg1, src_reg2, imm[15:0]};
                illegal = (imm[31:16] != {16{imm[15]}});
            end
            2'b10: begin
                word    = {opcode, imm2[25:0]};
                illegal = (imm2[31:26] != {6{imm2[25]}});
            end
            2'b11: illegal = 1'b1;
        endcase
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign in_ready  = (state == RUN) && !full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && !illegal;
    assign mem_valid = !empty;
    assign pop       = mem_valid && mem_ready;
    assign head      = fifo_mem[rd_ptr[PW-1:0]];
    assign mem_addr  = mem_valid ? head[EW-1:32] : '0;
    assign mem_wdata = mem_valid ? head[31:0] : 32'd0;
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN:   if (accept && in_last) state_nxt = DRAIN;
            DRAIN: if (empty) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (state == IDLE && start) begin
                addr      <= base_addr;
                err       <= 1'b0;
                err_count <= 8'd0;
            end else begin
                if (push) addr <= addr + ADDR_ONE;
                if (accept && illegal) begin
                    err <= 1'b1;
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
            end
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= {addr, word};
    end
endmodule

// File: tb/tb_instr_packer.sv
// Testbench for instr_packer: scenario tasks plus an address/data scoreboard on the write port.
module tb_instr_packer;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_last, mem_ready;
    logic [AW-1:0] base_addr;
    logic [1:0]    fmt;
    logic [5:0]    opcode, func;
    logic [4:0]    src_reg1, src_reg2, dest_reg, shamt;
    logic [31:0]   imm, imm2;
    logic          in_ready, mem_valid, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [7:0]    err_count;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    logic [AW+31:0] exp_q[$];

    instr_packer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .fmt(fmt),
        .opcode(opcode), .func(func), .src_reg1(src_reg1), .src_reg2(src_reg2),
        .dest_reg(dest_reg), .shamt(shamt), .imm(imm), .imm2(imm2),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .done(done), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: every completed write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && mem_valid && mem_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL write_order: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
        if (!rst && done) n_done++;
    end

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] r1, r2, rd, sh,
                                          input logic [5:0] fn);
        return (32'(op) << 26) | (32'(r1) << 21) | (32'(r2) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic begin_session(input logic [AW-1:0] b);
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] op, fn, input logic [4:0] r1, r2, rd, sh,
                        input logic [31:0] im, im2, input logic last);
        int t = 0;
        fmt = f; opcode = op; func = fn; src_reg1 = r1; src_reg2 = r2; dest_reg = rd; shamt = sh;
        imm = im; imm2 = im2; in_last = last; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
        end
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        n_vec++; if (mem_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_valid: got %b, required 0", mem_valid); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", done); end
        n_vec++; if ({err, err_count} !== 9'd0) begin n_err++; $display("FAIL reset_err: got err=%b count=%0d, required 0/0", err, err_count); end
        n_vec++; if ({mem_addr, mem_wdata} !== '0) begin n_err++; $display("FAIL reset_mem_bus: got addr=%h data=%h, required 0/0", mem_addr, mem_wdata); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_r_format();
        bit seen;
        int d0;
        mem_ready = 1'b1;
        d0 = n_done;
        begin_session(10'h010);
        exp_q.push_back({10'h010, 32'h00221820});
        send(2'b00, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 32'd0, 1'b1);
        wait_done(seen);
        n_vec++; if (!seen) begin n_err++; $display("FAIL r_done: got no done pulse, required one"); end
        tick(); tick(); tick();
        n_vec++; if (n_done - d0 != 1) begin n_err++; $display("FAIL r_done_count: got %0d pulses, required 1", n_done - d0); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL r_pending: got %0d unwritten, required 0", exp_q.size()); end
    endtask

    task automatic test_i_j_format();
        bit seen;
        begin_session(10'h020);
        exp_q.push_back({10'h020, 32'h2022FFFC});
        send(2'b01, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFC, 32'd0, 1'b0);
        exp_q.push_back({10'h021, 32'h08000010});
        send(2'b10, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h00000010, 1'b1);
        wait_done(seen);
        n_vec++; if (!seen || exp_q.size() != 0) begin n_err++; $display("FAIL ij_complete: got done=%b pending=%0d, required 1/0", seen, exp_q.size()); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ij_err: got %b, required 0", err); end
    endtask

    task automatic test_illegal();
        bit seen;
        begin_session(10'h100);
        send(2'b01, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 32'h00018000, 32'd0, 1'b0);
        exp_q.push_back({10'h100, enc_r(6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22)});
        send(2'b00, 6'h00, 6'h22, 5'd4, 5'd5, 5'd6, 5'd0, 32'd0, 32'd0, 1'b1);
        wait_done(seen);
        n_vec++; if (!seen || exp_q.size() != 0) begin n_err++; $display("FAIL ill_complete: got done=%b pending=%0d, required 1/0", seen, exp_q.size()); end
        n_vec++; if (err !== 1'b1 || err_count !== 8'd1) begin n_err++; $display("FAIL ill_err: got err=%b count=%0d, required 1/1", err, err_count); end
        // a new session clears the error state; an illegal last word still ends it
        begin_session(10'h180);
        @(negedge clk);
        n_vec++; if (err !== 1'b0 || err_count !== 8'd0) begin n_err++; $display("FAIL ill_clear: got err=%b count=%0d, required 0/0", err, err_count); end
        tick();
        send(2'b11, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        send(2'b10, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h04000000, 1'b1);
        wait_done(seen);
        n_vec++; if (!seen) begin n_err++; $display("FAIL ill_last_done: got no done pulse, required one"); end
        n_vec++; if (err_count !== 8'd2) begin n_err++; $display("FAIL ill_count: got %0d, required 2", err_count); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int t = 0;
        mem_ready = 1'b0;
        begin_session(10'h040);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({10'h040 + 10'(i), enc_r(6'h00, 5'(i), 5'(i + 1), 5'(i + 2), 5'(i), 6'h20 + 6'(i))});
            send(2'b00, 6'h00, 6'h20 + 6'(i), 5'(i), 5'(i + 1), 5'(i + 2), 5'(i), 32'd0, 32'd0, 1'b0);
            if (i == 1) begin
                base_addr = 10'h3A0;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        exp_q.push_back({10'h044, enc_r(6'h00, 5'd4, 5'd5, 5'd6, 5'd4, 6'h24)});
        fmt = 2'b00; opcode = 6'h00; func = 6'h24; src_reg1 = 5'd4; src_reg2 = 5'd5;
        dest_reg = 5'd6; shamt = 5'd4; in_last = 1'b1; in_valid = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b, required 0", in_ready); end
        n_vec++; if (mem_valid !== 1'b1 || mem_addr !== 10'h040) begin n_err++; $display("FAIL stall_head: got valid=%b addr=%h, required 1/040", mem_valid, mem_addr); end
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_in_ready: got %b, required 0", in_ready); end
        @(negedge clk);
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        wait_done(seen);
        n_vec++; if (!seen || exp_q.size() != 0) begin n_err++; $display("FAIL bp_complete: got done=%b pending=%0d, required 1/0", seen, exp_q.size()); end
    endtask

    task automatic test_wrap();
        bit seen;
        mem_ready = 1'b1;
        begin_session(10'h3FF);
        exp_q.push_back({10'h3FF, enc_r(6'h01, 5'd7, 5'd8, 5'd9, 5'd1, 6'h01)});
        send(2'b00, 6'h01, 6'h01, 5'd7, 5'd8, 5'd9, 5'd1, 32'd0, 32'd0, 1'b0);
        exp_q.push_back({10'h000, 32'h2022FFFC});
        send(2'b01, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFC, 32'd0, 1'b1);
        wait_done(seen);
        n_vec++; if (!seen || exp_q.size() != 0) begin n_err++; $display("FAIL wrap_complete: got done=%b pending=%0d, required 1/0", seen, exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        bit seen;
        int d0;
        mem_ready = 1'b0;
        begin_session(10'h050);
        for (int i = 0; i < 3; i++)
            send(2'b00, 6'h00, 6'h20, 5'(i), 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        n_vec++; if (mem_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid: got %b, required 1", mem_valid); end
        tick();
        d0 = n_done;
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_vec++; if (mem_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_outputs: got valid=%b ready=%b done=%b, required 0/0/0", mem_valid, in_ready, done);
        end
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_vec++; if (n_done != d0) begin n_err++; $display("FAIL mid_reset_done: got %0d pulses, required 0", n_done - d0); end
        begin_session(10'h200);
        exp_q.push_back({10'h200, enc_r(6'h00, 5'd3, 5'd3, 5'd3, 5'd0, 6'h25)});
        send(2'b00, 6'h00, 6'h25, 5'd3, 5'd3, 5'd3, 5'd0, 32'd0, 32'd0, 1'b1);
        wait_done(seen);
        n_vec++; if (!seen || exp_q.size() != 0) begin n_err++; $display("FAIL post_reset_session: got done=%b pending=%0d, required 1/0", seen, exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b0;
        base_addr = '0; fmt = 2'b00; opcode = '0; func = '0; src_reg1 = '0; src_reg2 = '0;
        dest_reg = '0; shamt = '0; imm = '0; imm2 = '0;
        #1;
        test_reset();
        test_r_format();
        test_i_j_format();
        test_illegal();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
